// File: rtl/relu_maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-ordered activation stream.
// Pairs of columns are reduced on the fly; even-row pair maxima wait in a half-width row buffer.
module relu_maxpool_2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 26,
    parameter int IMG_HEIGHT = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o
);

    localparam int CW   = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW   = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int HALF = IMG_WIDTH / 2;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] row_buf [HALF];
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  frame_done_q;

    logic                  col_last;
    logic                  row_last;
    logic                  emit_pos;
    logic                  accept;
    logic [BW-1:0]         buf_idx;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] buf_val;
    logic [DATA_WIDTH-1:0] pooled;

    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    assign emit_pos = col_q[0] & row_q[0];
    assign buf_idx  = BW'(col_q >> 1);

    // Valid/ready: a beat moves when valid && ready are both high at the rising edge.
    // Only the emitting pixel can be held off, and only while the output register is
    // full and not being drained; in_ready_o never looks at in_valid_i.
    assign in_ready_o = !clear_i && !(emit_pos && out_valid_q && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    assign hmax    = ($signed(in_data_i) > $signed(pair_q)) ? in_data_i : pair_q;
    assign buf_val = row_buf[buf_idx];
    assign pooled  = ($signed(hmax) > $signed(buf_val)) ? hmax : buf_val;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (clear_i) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && col_last && row_last;
            if (accept) begin
                if (!col_q[0]) begin
                    pair_q <= in_data_i;
                end
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            // A fresh emit overwrites the register in the same cycle the old value drains.
            if (accept && emit_pos) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pooled;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Each entry is written on an even row before the matching odd row reads it.
    always_ff @(posedge clk_i) begin
        if (accept && col_q[0] && !row_q[0]) begin
            row_buf[buf_idx] <= hmax;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_2x2_stream.sv
// Directed bench for relu_maxpool_2x2_stream: a 4x4 instance for the main cases
// and a 5x5 instance for odd-dimension floor behaviour.
module tb_relu_maxpool_2x2_stream;

    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          clear;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          valid4, ready4, ovalid4, fd4;
    logic          valid5, ready5, ovalid5, fd5;
    logic [DW-1:0] odata4, odata5;

    relu_maxpool_2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_data_i(in_data), .in_valid_i(valid4), .in_ready_o(ready4),
        .out_data_o(odata4), .out_valid_o(ovalid4), .out_ready_i(out_ready),
        .frame_done_o(fd4)
    );

    relu_maxpool_2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_data_i(in_data), .in_valid_i(valid5), .in_ready_o(ready5),
        .out_data_o(odata5), .out_valid_o(ovalid5), .out_ready_i(out_ready),
        .frame_done_o(fd5)
    );

    int checks = 0;
    int errors = 0;
    int fd4_cnt = 0;
    int fd5_cnt = 0;
    int acc5 = 0;
    logic [DW-1:0] exp4_q[$];
    logic [DW-1:0] exp5_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // scoreboard: every output transfer is matched against the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovalid4 && out_ready) begin
                if (exp4_q.size() == 0) check("sb4_unexpected", DW'(exp4_q.size()), DW'(1));
                else                    check("sb4_data", odata4, exp4_q.pop_front());
            end
            if (ovalid5 && out_ready) begin
                if (exp5_q.size() == 0) check("sb5_unexpected", DW'(exp5_q.size()), DW'(1));
                else                    check("sb5_data", odata5, exp5_q.pop_front());
            end
            if (fd4) fd4_cnt++;
            if (fd5) fd5_cnt++;
            if (valid5 && ready5) acc5++;
        end
    end

    // driver: present one pixel, wait (bounded) for ready, complete the handshake
    task automatic drive(input bit sel5, input logic [DW-1:0] v, output int waited);
        in_data = v;
        if (sel5) valid5 = 1'b1;
        else      valid4 = 1'b1;
        waited = 0;
        #1;
        while (!(sel5 ? ready5 : ready4) && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!(sel5 ? ready5 : ready4)) check("in_ready_timeout", DW'(sel5 ? ready5 : ready4), DW'(1));
        else @(posedge clk);
        #1;
        valid4 = 1'b0;
        valid5 = 1'b0;
    endtask

    task automatic frame4_plain();
        int w;
        for (int i = 0; i < 16; i++) drive(1'b0, DW'(i), w);
    endtask

    task automatic drain_check(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check(tag, DW'(exp4_q.size()), DW'(0));
    endtask

    int sgn [16] = '{-8, -3, 7, 7, -5, -9, 7, 7, 1, -100, 0, -1, -2, 3, -4, -4};

    initial begin
        int w;
        int fd_before;
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1; in_data = '0;
        valid4 = 1'b0; valid5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid4", DW'(ovalid4), DW'(0));
        check("rst_out_data4", odata4, DW'(0));
        check("rst_frame_done4", DW'(fd4), DW'(0));
        check("rst_in_ready4", DW'(ready4), DW'(1));
        check("rst_out_valid5", DW'(ovalid5), DW'(0));
        check("rst_out_data5", odata5, DW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // case 1: raster 0..15, latency and frame_done timing
        exp4_q = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, DW'(i), w);
            if (i == 5 || i == 7 || i == 13 || i == 15) begin
                @(negedge clk);
                check($sformatf("c1_lat_valid_%0d", i), DW'(ovalid4), DW'(1));
                check($sformatf("c1_lat_data_%0d", i), odata4, DW'(i));
                if (i == 15) check("c1_frame_done", DW'(fd4), DW'(1));
            end
        end
        drain_check("c1_drained");
        check("c1_fd_count", DW'(fd4_cnt), DW'(1));

        // case 2: signed blocks and ties
        exp4_q = '{DW'(-3), DW'(7), DW'(3), DW'(0)};
        for (int i = 0; i < 16; i++) drive(1'b0, DW'(sgn[i]), w);
        drain_check("c2_drained");

        // case 3: backpressure
        exp4_q = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, DW'(i), w);
            if (i == 6) check("c3_no_stall_6", DW'(w), DW'(0));
        end
        in_data = DW'(7); valid4 = 1'b1;
        #1;
        check("c3_stall_7", DW'(ready4), DW'(0));
        repeat (2) @(posedge clk);
        #1;
        check("c3_stall_7_hold", DW'(ready4), DW'(0));
        check("c3_hold_data_5", odata4, DW'(5));
        out_ready = 1'b1;
        #1;
        check("c3_release_7", DW'(ready4), DW'(1));
        @(posedge clk);
        #1;
        valid4 = 1'b0; out_ready = 1'b0;
        for (int i = 8; i < 13; i++) begin
            drive(1'b0, DW'(i), w);
            check($sformatf("c3_no_stall_%0d", i), DW'(w), DW'(0));
        end
        in_data = DW'(13); valid4 = 1'b1;
        #1;
        check("c3_stall_13", DW'(ready4), DW'(0));
        repeat (3) @(posedge clk);
        #1;
        check("c3_hold_valid_7", DW'(ovalid4), DW'(1));
        check("c3_hold_data_7", odata4, DW'(7));
        out_ready = 1'b1;
        for (int i = 13; i < 16; i++) drive(1'b0, DW'(i), w);
        drain_check("c3_drained");

        // case 4: 5x5 floor semantics on the second instance
        exp5_q = '{DW'(6), DW'(8), DW'(16), DW'(18)};
        for (int i = 0; i < 25; i++) drive(1'b1, DW'(i), w);
        @(negedge clk);
        check("c4_frame_done", DW'(fd5), DW'(1));
        repeat (3) @(posedge clk);
        #1;
        check("c4_drained", DW'(exp5_q.size()), DW'(0));
        check("c4_accepted", DW'(acc5), DW'(25));
        check("c4_fd_count", DW'(fd5_cnt), DW'(1));

        // case 5: clear mid-frame with an output pending
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) drive(1'b0, DW'(i), w);
        fd_before = fd4_cnt;
        clear = 1'b1; in_data = DW'(99); valid4 = 1'b1;
        #1;
        check("c5_ready_in_clear", DW'(ready4), DW'(0));
        @(posedge clk);
        #1;
        clear = 1'b0; valid4 = 1'b0;
        check("c5_valid_cleared", DW'(ovalid4), DW'(0));
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("c5_no_frame_done", DW'(fd4_cnt), DW'(fd_before));
        exp4_q = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        frame4_plain();
        drain_check("c5_drained");

        // case 6: async reset with an output pending
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b0, DW'(i), w);
        @(negedge clk);
        check("c6_pre_valid", DW'(ovalid4), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("c6_async_valid", DW'(ovalid4), DW'(0));
        check("c6_async_data", odata4, DW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp4_q = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        frame4_plain();
        drain_check("c6_drained");
        check("fd4_total", DW'(fd4_cnt), DW'(5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
